// File: rtl/ds_scoreboard.sv
// ds_scoreboard: decode-stage register interlock and operand forwarding for the MIPS pipeline
//   clk, reset   : clock, synchronous active-high reset
//   flush        : clear all pending-write counters
//   src_use/src_addr/rf_rdata : per-source read enable, address, register-file data
//   fwd_valid/fwd_addr/fwd_ready/fwd_data : forwarding ports, index 0 youngest (EXE)
//   id_we/id_dest : destination of the instruction in ID
//   issue_fire   : ID to EXE transfer, wb_fire/wb_dest : GPR commit
//   src_value    : resolved operands, stall : decode must hold
//   perf_stall_cnt : stall-cycle counter, present only with SB_PERF_CNT_EN defined
module ds_scoreboard #(
  parameter int DATA_W  = 32,
  parameter int RADDR_W = 5,
  parameter int NUM_SRC = 2,
  parameter int NUM_FWD = 3,
  parameter int CNT_W   = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic [NUM_SRC-1:0]         src_use,
  input  logic [NUM_SRC*RADDR_W-1:0] src_addr,
  input  logic [NUM_SRC*DATA_W-1:0]  rf_rdata,
  input  logic [NUM_FWD-1:0]         fwd_valid,
  input  logic [NUM_FWD*RADDR_W-1:0] fwd_addr,
  input  logic [NUM_FWD-1:0]         fwd_ready,
  input  logic [NUM_FWD*DATA_W-1:0]  fwd_data,
  input  logic                       id_we,
  input  logic [RADDR_W-1:0]         id_dest,
  input  logic                       issue_fire,
  input  logic                       wb_fire,
  input  logic [RADDR_W-1:0]         wb_dest,
  output logic [NUM_SRC*DATA_W-1:0]  src_value,
`ifdef SB_PERF_CNT_EN
  output logic                       stall,
  output logic [31:0]                perf_stall_cnt
`else
  output logic                       stall
`endif
);
  localparam int NREG = 1 << RADDR_W;
  logic [CNT_W-1:0]   r_pend [NREG];
  logic               w_inc, w_dec, w_sat, w_hit, w_rdy;
  logic [RADDR_W-1:0] w_a;
  logic [DATA_W-1:0]  w_fd;
  logic [NUM_SRC-1:0] w_src_stall;
  assign w_inc = issue_fire && id_we && id_dest != '0;
  assign w_dec = wb_fire && wb_dest != '0 && r_pend[wb_dest] != '0;
  assign w_sat = id_we && id_dest != '0 && &r_pend[id_dest];
  assign stall = |w_src_stall || w_sat;
  // register 0 is never incremented or decremented, so it stays at its reset value of 0
  always_ff @(posedge clk)
    for (int r = 0; r < NREG; r++)
      r_pend[r] <= (reset || flush) ? '0 :
                   r_pend[r] + CNT_W'(w_inc && id_dest == RADDR_W'(r))
                             - CNT_W'(w_dec && wb_dest == RADDR_W'(r));
  // ports scanned oldest to youngest so the youngest matching port is the last one kept
  always_comb begin
    src_value = rf_rdata;
    w_src_stall = '0;
    w_a = '0;
    w_hit = 1'b0;
    w_rdy = 1'b0;
    w_fd = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      w_a = src_addr[i*RADDR_W +: RADDR_W];
      w_hit = 1'b0;
      w_rdy = 1'b0;
      w_fd = '0;
      for (int k = NUM_FWD-1; k >= 0; k--)
        if (fwd_valid[k] && fwd_addr[k*RADDR_W +: RADDR_W] == w_a) begin
          w_hit = 1'b1;
          w_rdy = fwd_ready[k];
          w_fd = fwd_data[k*DATA_W +: DATA_W];
        end
      if (src_use[i] && w_a != '0) begin
        if (w_hit && w_rdy) src_value[i*DATA_W +: DATA_W] = w_fd;
        w_src_stall[i] = w_hit ? !w_rdy : r_pend[w_a] != '0;
      end
    end
  end
`ifdef SB_PERF_CNT_EN
  logic [31:0] r_perf;
  assign perf_stall_cnt = r_perf;
  always_ff @(posedge clk)
    r_perf <= reset ? '0 : r_perf + 32'(stall && !flush);
`endif
endmodule

// File: tb/tb_ds_scoreboard.sv
// tb_ds_scoreboard: directed scoreboard bench for ds_scoreboard
module tb_ds_scoreboard;
  logic        clk = 1'b0;
  logic        reset, flush, id_we, issue_fire, wb_fire, stall;
  logic [1:0]  src_use;
  logic [9:0]  src_addr;
  logic [63:0] rf_rdata, src_value;
  logic [2:0]  fwd_valid, fwd_ready;
  logic [14:0] fwd_addr;
  logic [95:0] fwd_data;
  logic [4:0]  id_dest, wb_dest;
`ifdef SB_PERF_CNT_EN
  logic [31:0] perf_stall_cnt;
`endif
  typedef struct {int n; logic s; logic [31:0] v0, v1;} exp_t;
  exp_t q[$];
  int checks = 0, failures = 0, step = 0, m_perf = 0;
  always #5 clk = ~clk;
  ds_scoreboard dut (
    .clk(clk), .reset(reset), .flush(flush), .src_use(src_use), .src_addr(src_addr),
    .rf_rdata(rf_rdata), .fwd_valid(fwd_valid), .fwd_addr(fwd_addr), .fwd_ready(fwd_ready),
    .fwd_data(fwd_data), .id_we(id_we), .id_dest(id_dest), .issue_fire(issue_fire),
    .wb_fire(wb_fire), .wb_dest(wb_dest), .src_value(src_value),
`ifdef SB_PERF_CNT_EN
    .stall(stall), .perf_stall_cnt(perf_stall_cnt)
`else
    .stall(stall)
`endif
  );
  function automatic logic [31:0] rfv(input logic [4:0] a);
    return 32'hF000_0000 | {27'd0, a};
  endfunction
  assign rf_rdata = {rfv(src_addr[9:5]), rfv(src_addr[4:0])};
  task automatic clr();
    flush = 0; id_we = 0; issue_fire = 0; wb_fire = 0; id_dest = 0; wb_dest = 0;
    src_use = 0; src_addr = 0; fwd_valid = 0; fwd_ready = 0; fwd_addr = 0; fwd_data = 0;
  endtask
  task automatic rd(input logic [1:0] u, input logic [4:0] a1, input logic [4:0] a0);
    src_use = u; src_addr = {a1, a0};
  endtask
  task automatic fw(input int k, input logic rdy, input logic [4:0] a, input logic [31:0] d);
    fwd_valid[k] = 1'b1; fwd_ready[k] = rdy; fwd_addr[k*5 +: 5] = a; fwd_data[k*32 +: 32] = d;
  endtask
  task automatic iss(input logic [4:0] d);
    id_we = 1; id_dest = d; issue_fire = 1;
  endtask
  task automatic wb(input logic [4:0] d);
    wb_fire = 1; wb_dest = d;
  endtask
  task automatic go(input logic s, input logic [31:0] v0, input logic [31:0] v1);
    exp_t e;
    step++;
    e.n = step; e.s = s; e.v0 = v0; e.v1 = v1;
    q.push_back(e);
    if (s && !flush) m_perf++;
    @(posedge clk); #1;
    clr();
  endtask
  always @(negedge clk)
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      if (stall !== e.s) begin
        failures++;
        $display("FAIL step%0d stall got=%0b exp=%0b", e.n, stall, e.s);
      end
      if (!e.s) begin
        checks++;
        if (src_value !== {e.v1, e.v0}) begin
          failures++;
          $display("FAIL step%0d src_value got=%h exp=%h", e.n, src_value, {e.v1, e.v0});
        end
      end
    end
  initial begin
    clr();
    reset = 1;
    repeat (2) @(posedge clk);
    #1 reset = 0;
    rd(2'b11, 5'd2, 5'd1);                go(0, rfv(1), rfv(2));
    iss(8);                               go(0, rfv(0), rfv(0));
    rd(2'b11, 5'd0, 5'd8); fw(0, 1, 8, 32'h1234); go(0, 32'h1234, rfv(0));
    rd(2'b01, 5'd0, 5'd8);                go(1, 0, 0);
    rd(2'b10, 5'd8, 5'd0); fw(2, 1, 8, 32'h55); wb(8); go(0, rfv(0), 32'h55);
    rd(2'b10, 5'd8, 5'd0);                go(0, rfv(0), rfv(8));
    iss(9);                               go(0, rfv(0), rfv(0));
    rd(2'b01, 5'd0, 5'd9); fw(0, 0, 9, 32'hDEAD); go(1, 0, 0);
    rd(2'b01, 5'd0, 5'd9); fw(1, 1, 9, 32'hCAFE); go(0, 32'hCAFE, rfv(0));
    rd(2'b10, 5'd9, 5'd0); fw(2, 1, 9, 32'hCAFE); wb(9); go(0, rfv(0), 32'hCAFE);
    rd(2'b11, 5'd3, 5'd3); fw(0, 1, 3, 32'hA); fw(2, 1, 3, 32'hB); go(0, 32'hA, 32'hA);
    rd(2'b01, 5'd0, 5'd3); fw(0, 0, 3, 32'hA); fw(2, 1, 3, 32'hB); go(1, 0, 0);
    rd(2'b11, 5'd2, 5'd1); fw(1, 1, 7, 32'h77); go(0, rfv(1), rfv(2));
    iss(4);                               go(0, rfv(0), rfv(0));
    iss(4);                               go(0, rfv(0), rfv(0));
    iss(4);                               go(0, rfv(0), rfv(0));
    id_we = 1; id_dest = 4;               go(1, 0, 0);
    iss(4); wb(4);                        go(1, 0, 0);
    id_we = 1; id_dest = 4;               go(1, 0, 0);
    wb(4);                                go(0, rfv(0), rfv(0));
    id_we = 1; id_dest = 4;               go(0, rfv(0), rfv(0));
    wb(6);                                go(0, rfv(0), rfv(0));
    rd(2'b01, 5'd0, 5'd6);                go(0, rfv(6), rfv(0));
    iss(5);                               go(0, rfv(0), rfv(0));
    iss(5);                               go(0, rfv(0), rfv(0));
    rd(2'b10, 5'd5, 5'd0);                go(1, 0, 0);
    rd(2'b00, 5'd5, 5'd5);                go(0, rfv(5), rfv(5));
    rd(2'b10, 5'd5, 5'd0); flush = 1; iss(5); wb(5); go(1, 0, 0);
    rd(2'b11, 5'd4, 5'd5);                go(0, rfv(5), rfv(4));
    rd(2'b01, 5'd0, 5'd5); fw(2, 1, 5, 32'h99); go(0, 32'h99, rfv(0));
    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    if (q.size() > 0) begin
      checks++; failures++;
      $display("FAIL drain pending got=%0d exp=0", q.size());
    end
`ifdef SB_PERF_CNT_EN
    checks++;
    if (perf_stall_cnt !== 32'(m_perf)) begin
      failures++;
      $display("FAIL perf_stall_cnt got=%0d exp=%0d", perf_stall_cnt, m_perf);
    end
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
